// File: rtl/data_mem_mmio.sv
// Data memory for the RV32 MEM stage. The lowest word indices are memory-mapped
// input/output channels with valid/ready handshakes, and RAM fills the rest.
module data_mem_mmio #(
    parameter int DEPTH   = 256,
    parameter int NUM_IN  = 1,
    parameter int NUM_OUT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            addr,
    input  logic [31:0]            wdata,
    input  logic [2:0]             funct3,
    input  logic                   lw_en,
    input  logic                   sw_en,
    output logic [31:0]            rd_data,
    output logic                   rd_valid,
    output logic                   err,
    output logic                   stall,
    input  logic [32*NUM_IN-1:0]   in_data,
    input  logic [NUM_IN-1:0]      in_valid,
    output logic [NUM_IN-1:0]      in_ready,
    output logic [32*NUM_OUT-1:0]  out_data,
    output logic [NUM_OUT-1:0]     out_valid,
    input  logic [NUM_OUT-1:0]     out_ready
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);
    localparam logic [29:0] NIN_W   = 30'(NUM_IN);
    localparam logic [29:0] NIO_W   = 30'(NUM_IN + NUM_OUT);

    logic [31:0]        mem [DEPTH];
    logic [31:0]        in_reg_q  [NUM_IN];
    logic [31:0]        out_reg_q [NUM_OUT];
    logic [NUM_IN-1:0]  in_full_q;
    logic [NUM_OUT-1:0] out_valid_q;
    logic [31:0]        rd_data_q;
    logic               rd_valid_q, err_q;

    logic [29:0]        widx;
    logic [1:0]         lane;
    logic [AW-1:0]      ram_idx;
    logic               size_ok, misal, is_in, is_out, is_ram, fault, blocked;
    logic               ld_acc, st_acc, ld_fault;
    logic [NUM_IN-1:0]  in_hit;
    logic [NUM_OUT-1:0] out_hit;
    logic [31:0]        src_word, shifted, load_ext, wsh, merged;
    logic [3:0]         be;

    assign widx    = addr[31:2];
    assign lane    = addr[1:0];
    assign ram_idx = widx[AW-1:0];
    assign is_in   = widx < NIN_W;
    assign is_out  = !is_in && (widx < NIO_W);
    assign is_ram  = !is_in && !is_out;

    always_comb begin
        size_ok  = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b101);
        misal    = ((funct3[1:0] == 2'b01) && addr[0]) ||
                   ((funct3[1:0] == 2'b10) && (lane != 2'b00));
        fault    = (lw_en || sw_en) &&
                   (!size_ok || misal || (widx >= DEPTH_W) || (lw_en && sw_en) || (sw_en && is_in));
        src_word = mem[ram_idx];
        blocked  = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            in_hit[k] = (widx == 30'(k));
            if (in_hit[k]) begin
                src_word = in_reg_q[k];
                blocked  = lw_en && !in_full_q[k];
            end
        end
        for (int k = 0; k < NUM_OUT; k++) begin
            out_hit[k] = (widx == 30'(NUM_IN + k));
            if (out_hit[k]) begin
                src_word = out_reg_q[k];
                blocked  = sw_en && out_valid_q[k] && !out_ready[k];
            end
        end
        // A fault takes precedence over backpressure so faulting accesses never stall.
        stall    = !fault && blocked;
        ld_acc   = lw_en && !sw_en && !fault && !blocked;
        st_acc   = sw_en && !lw_en && !fault && !blocked;
        ld_fault = lw_en && fault;

        shifted = src_word >> {lane, 3'b000};
        case (funct3)
            3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_ext = {24'd0, shifted[7:0]};
            3'b101:  load_ext = {16'd0, shifted[15:0]};
            default: load_ext = shifted;
        endcase

        case (funct3[1:0])
            2'b00:   be = 4'b0001 << lane;
            2'b01:   be = 4'b0011 << {addr[1], 1'b0};
            default: be = 4'b1111;
        endcase
        wsh = wdata << {lane, 3'b000};
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = be[i] ? wsh[8*i +: 8] : src_word[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q   <= 32'd0;
            rd_valid_q  <= 1'b0;
            err_q       <= 1'b0;
            in_full_q   <= '0;
            out_valid_q <= '0;
            for (int k = 0; k < NUM_OUT; k++) out_reg_q[k] <= 32'd0;
        end else begin
            rd_valid_q <= ld_acc || ld_fault;
            err_q      <= fault;
            if (ld_acc)        rd_data_q <= load_ext;
            else if (ld_fault) rd_data_q <= 32'd0;
            // A load only hits a full channel, a capture only an empty one, so they never collide.
            for (int k = 0; k < NUM_IN; k++) begin
                if (ld_acc && in_hit[k]) begin
                    in_full_q[k] <= 1'b0;
                end else if (in_valid[k] && !in_full_q[k]) begin
                    in_full_q[k] <= 1'b1;
                    in_reg_q[k]  <= in_data[32*k +: 32];
                end
            end
            for (int k = 0; k < NUM_OUT; k++) begin
                if (st_acc && out_hit[k]) begin
                    out_reg_q[k]   <= merged;
                    out_valid_q[k] <= 1'b1;
                end else if (out_valid_q[k] && out_ready[k]) begin
                    out_valid_q[k] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && st_acc && is_ram) mem[ram_idx] <= merged;
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign err       = err_q;
    assign in_ready  = ~in_full_q;
    assign out_valid = out_valid_q;

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
        assign out_data[32*g +: 32] = out_reg_q[g];
    end
endmodule

// File: tb/tb_data_mem_mmio.sv
// Bench for data_mem_mmio: a default instance for lanes, handshakes, faults and
// random RAM traffic, and a 3-in/2-out/64-word instance for the channel map.
module tb_data_mem_mmio;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] a_addr = 0, a_wdata = 0, a_rd_data;
    logic [2:0]  a_f3 = 3'd2;
    logic        a_lw = 0, a_sw = 0, a_rd_valid, a_err, a_stall;
    logic [31:0] a_in_data = 0, a_out_data;
    logic [0:0]  a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0;

    logic [31:0] b_addr = 0, b_wdata = 0, b_rd_data;
    logic [2:0]  b_f3 = 3'd2;
    logic        b_lw = 0, b_sw = 0, b_rd_valid, b_err, b_stall;
    logic [95:0] b_in_data = 0;
    logic [63:0] b_out_data;
    logic [2:0]  b_in_valid = 0, b_in_ready;
    logic [1:0]  b_out_valid, b_out_ready = 0;

    data_mem_mmio u_a (
        .clk(clk), .rst(rst), .addr(a_addr), .wdata(a_wdata), .funct3(a_f3),
        .lw_en(a_lw), .sw_en(a_sw), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
        .err(a_err), .stall(a_stall), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .out_data(a_out_data), .out_valid(a_out_valid),
        .out_ready(a_out_ready)
    );

    data_mem_mmio #(.DEPTH(64), .NUM_IN(3), .NUM_OUT(2)) u_b (
        .clk(clk), .rst(rst), .addr(b_addr), .wdata(b_wdata), .funct3(b_f3),
        .lw_en(b_lw), .sw_en(b_sw), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
        .err(b_err), .stall(b_stall), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .out_data(b_out_data), .out_valid(b_out_valid),
        .out_ready(b_out_ready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic lw, input logic sw, input logic [31:0] ad,
                          input logic [31:0] wd, input logic [2:0] f3, output logic st);
        a_lw = lw; a_sw = sw; a_addr = ad; a_wdata = wd; a_f3 = f3;
        #1 st = a_stall;
        tick();
        a_lw = 0; a_sw = 0;
    endtask

    task automatic do_req_b(input logic lw, input logic sw, input logic [31:0] ad,
                            input logic [31:0] wd, input logic [2:0] f3, output logic st);
        b_lw = lw; b_sw = sw; b_addr = ad; b_wdata = wd; b_f3 = f3;
        #1 st = b_stall;
        tick();
        b_lw = 0; b_sw = 0;
    endtask

    typedef struct {
        logic        lw, sw;
        logic [31:0] ad, wd;
        logic [2:0]  f3;
        logic        e_err, chk, e_rdv;
        logic [31:0] e_rd;
        string       nm;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input logic lw, input logic sw, input logic [31:0] ad,
                                input logic [31:0] wd, input logic [2:0] f3, input logic e_err,
                                input logic chk, input logic e_rdv, input logic [31:0] e_rd,
                                input string nm);
        vec_t v;
        v.lw = lw; v.sw = sw; v.ad = ad; v.wd = wd; v.f3 = f3;
        v.e_err = e_err; v.chk = chk; v.e_rdv = e_rdv; v.e_rd = e_rd; v.nm = nm;
        tbl.push_back(v);
    endfunction

    // Reference RAM for the random phase: byte array covering byte addresses 64..127.
    logic [7:0] mref [64];

    function automatic int acc_size(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic m_fault(input logic [31:0] ad, input logic [2:0] f3);
        if (!(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)) return 1'b1;
        return (ad % acc_size(f3)) != 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] ad, input logic [2:0] f3);
        int n = acc_size(f3);
        logic [31:0] v = 0;
        for (int i = 0; i < n; i++) v = v | (32'(mref[ad - 64 + i]) << (8 * i));
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 1);
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic st;
        logic [2:0] f3_pool [10];
        f3_pool[0] = 0; f3_pool[1] = 1; f3_pool[2] = 2; f3_pool[3] = 4; f3_pool[4] = 5;
        f3_pool[5] = 2; f3_pool[6] = 0; f3_pool[7] = 3; f3_pool[8] = 6; f3_pool[9] = 7;

        repeat (3) tick();
        rst = 0;
        #1;
        check("reset rd_data", a_rd_data, 0);
        check("reset rd_valid", 32'(a_rd_valid), 0);
        check("reset err", 32'(a_err), 0);
        check("reset in_ready", 32'(a_in_ready), 1);
        check("reset out_valid", 32'(a_out_valid), 0);
        check("reset out_data", a_out_data, 0);
        check("reset stall", 32'(a_stall), 0);

        add(0, 1, 32'h40, 32'h80FF7F01, 3'b010, 0, 1, 0, 0, "sw 0x40");
        add(1, 0, 32'h40, 0, 3'b000, 0, 1, 1, 32'h00000001, "lb 0x40");
        add(1, 0, 32'h43, 0, 3'b000, 0, 1, 1, 32'hFFFFFF80, "lb 0x43");
        add(1, 0, 32'h43, 0, 3'b100, 0, 1, 1, 32'h00000080, "lbu 0x43");
        add(1, 0, 32'h42, 0, 3'b001, 0, 1, 1, 32'hFFFF80FF, "lh 0x42");
        add(1, 0, 32'h42, 0, 3'b101, 0, 1, 1, 32'h000080FF, "lhu 0x42");
        add(0, 1, 32'h41, 32'hAA, 3'b000, 0, 1, 0, 0, "sb 0x41");
        add(1, 0, 32'h40, 0, 3'b010, 0, 1, 1, 32'h80FFAA01, "lw 0x40");
        add(1, 0, 32'h41, 0, 3'b010, 1, 1, 1, 32'h0, "lw misaligned");
        add(1, 0, 32'h43, 0, 3'b001, 1, 1, 1, 32'h0, "lh misaligned");
        add(0, 1, 32'h0, 32'h5, 3'b010, 1, 1, 0, 0, "sw input chan");
        add(1, 0, 32'h400, 0, 3'b010, 1, 1, 1, 32'h0, "lw word DEPTH");
        add(1, 0, 32'h40, 0, 3'b011, 1, 1, 1, 32'h0, "funct3 011");
        add(1, 1, 32'h40, 32'h0, 3'b010, 1, 0, 0, 0, "lw+sw both");
        add(0, 1, 32'h42, 32'h0, 3'b010, 1, 1, 0, 0, "sw misaligned");
        add(0, 1, 32'h40, 32'h0, 3'b011, 1, 1, 0, 0, "sw funct3 011");
        add(1, 0, 32'h40, 0, 3'b010, 0, 1, 1, 32'h80FFAA01, "lw after faults");
        add(1, 0, 32'h40, 0, 3'b100, 0, 1, 1, 32'h00000001, "lbu b2b");
        foreach (tbl[i]) begin
            do_req(tbl[i].lw, tbl[i].sw, tbl[i].ad, tbl[i].wd, tbl[i].f3, st);
            check({tbl[i].nm, " stall"}, 32'(st), 0);
            check({tbl[i].nm, " err"}, 32'(a_err), 32'(tbl[i].e_err));
            if (tbl[i].chk) check({tbl[i].nm, " rd_valid"}, 32'(a_rd_valid), 32'(tbl[i].e_rdv));
            if (tbl[i].chk && tbl[i].e_rdv) check({tbl[i].nm, " rd_data"}, a_rd_data, tbl[i].e_rd);
        end
        check("in_ready after faults", 32'(a_in_ready), 1);

        // Input channel handshake
        a_lw = 1; a_addr = 0; a_f3 = 3'b010;
        #1 check("in load stall", 32'(a_stall), 1);
        tick();
        check("in stalled no rd_valid", 32'(a_rd_valid), 0);
        check("in stall held", 32'(a_stall), 1);
        a_in_data = 32'h12345678; a_in_valid = 1;
        #1 check("in_ready before capture", 32'(a_in_ready), 1);
        tick();
        a_in_valid = 0;
        #1;
        check("in stall released", 32'(a_stall), 0);
        check("in_ready while full", 32'(a_in_ready), 0);
        tick();
        a_lw = 0;
        check("in load rd_valid", 32'(a_rd_valid), 1);
        check("in load rd_data", a_rd_data, 32'h12345678);
        check("in_ready after load", 32'(a_in_ready), 1);

        // Load of a full channel while new data is offered
        a_in_data = 32'h0000A0A0; a_in_valid = 1;
        tick();
        a_in_data = 32'h0000B0B0;
        a_lw = 1; a_addr = 0; a_f3 = 3'b010;
        #1;
        check("same-cycle in_ready", 32'(a_in_ready), 0);
        check("same-cycle stall", 32'(a_stall), 0);
        tick();
        a_lw = 0;
        check("same-cycle old data", a_rd_data, 32'h0000A0A0);
        check("same-cycle in_ready reopens", 32'(a_in_ready), 1);
        tick();
        a_in_valid = 0;
        #1 check("new data captured", 32'(a_in_ready), 0);
        do_req(1, 0, 32'h1, 0, 3'b000, st);
        check("in lb byte1", a_rd_data, 32'hFFFFFFB0);

        // Output channel backpressure
        a_out_ready = 0;
        do_req(0, 1, 32'h4, 32'hDEADBEEF, 3'b010, st);
        check("out first stall", 32'(st), 0);
        check("out_valid set", 32'(a_out_valid), 1);
        check("out_data first", a_out_data, 32'hDEADBEEF);
        a_sw = 1; a_addr = 4; a_wdata = 32'h11223344; a_f3 = 3'b010;
        #1 check("out second stall", 32'(a_stall), 1);
        tick();
        check("out_data held", a_out_data, 32'hDEADBEEF);
        a_out_ready = 1;
        #1 check("out stall released", 32'(a_stall), 0);
        tick();
        a_sw = 0;
        check("out_data second", a_out_data, 32'h11223344);
        check("out_valid stays", 32'(a_out_valid), 1);
        tick();
        check("out_valid consumed", 32'(a_out_valid), 0);
        do_req(1, 0, 32'h4, 0, 3'b010, st);
        check("out readback", a_rd_data, 32'h11223344);
        check("out readback no side effect", 32'(a_out_valid), 0);
        do_req(0, 1, 32'h5, 32'hAB, 3'b000, st);
        check("out sb merge", a_out_data, 32'h1122AB44);
        check("out sb valid", 32'(a_out_valid), 1);

        // Reset during a pending load
        a_out_ready = 0;
        do_req(0, 1, 32'h4, 32'h77, 3'b010, st);
        a_in_data = 32'h5; a_in_valid = 1;
        tick();
        a_in_valid = 0;
        a_lw = 1; a_addr = 32'h40; a_f3 = 3'b010; rst = 1;
        tick();
        rst = 0; a_lw = 0;
        #1;
        check("mid-reset rd_valid", 32'(a_rd_valid), 0);
        check("mid-reset rd_data", a_rd_data, 0);
        check("mid-reset out_valid", 32'(a_out_valid), 0);
        check("mid-reset out_data", a_out_data, 0);
        check("mid-reset in_ready", 32'(a_in_ready), 1);
        do_req(1, 0, 32'h40, 0, 3'b010, st);
        check("RAM kept over reset", a_rd_data, 32'h80FFAA01);

        // Parameter sweep instance: in 0..2, out 3..4, RAM 5..63
        b_in_data[95:64] = 32'hCAFE0002; b_in_valid = 3'b100;
        tick();
        b_in_valid = 0;
        check("B in_ready map", 32'(b_in_ready), 32'b011);
        do_req_b(1, 0, 32'h8, 0, 3'b010, st);
        check("B in chan2 data", b_rd_data, 32'hCAFE0002);
        check("B in_ready restored", 32'(b_in_ready), 32'b111);
        b_lw = 1; b_addr = 32'h4; b_f3 = 3'b010;
        #1 check("B empty chan1 stalls", 32'(b_stall), 1);
        b_lw = 0;
        do_req_b(0, 1, 32'hC, 32'h33333333, 3'b010, st);
        check("B out chan0 valid", 32'(b_out_valid), 32'b01);
        check("B out chan0 data", b_out_data[31:0], 32'h33333333);
        do_req_b(0, 1, 32'h10, 32'h44444444, 3'b010, st);
        check("B out chan1 valid", 32'(b_out_valid), 32'b11);
        check("B out chan1 data", b_out_data[63:32], 32'h44444444);
        do_req_b(0, 1, 32'h14, 32'h55555555, 3'b010, st);
        check("B word5 store stall", 32'(st), 0);
        check("B word5 store err", 32'(b_err), 0);
        do_req_b(1, 0, 32'h14, 0, 3'b010, st);
        check("B word5 is RAM", b_rd_data, 32'h55555555);
        check("B outs untouched", 32'(b_out_valid), 32'b11);
        do_req_b(0, 1, 32'hFC, 32'h63636363, 3'b010, st);
        do_req_b(1, 0, 32'hFC, 0, 3'b010, st);
        check("B word63 err", 32'(b_err), 0);
        check("B word63 data", b_rd_data, 32'h63636363);
        do_req_b(1, 0, 32'h100, 0, 3'b010, st);
        check("B word64 err", 32'(b_err), 1);
        check("B word64 rd_data", b_rd_data, 0);
        do_req_b(0, 1, 32'h8, 32'h1, 3'b010, st);
        check("B store in chan err", 32'(b_err), 1);

        // Random RAM traffic against the byte-level model
        for (int w = 0; w < 16; w++) begin
            logic [31:0] v = $urandom;
            do_req(0, 1, 32'(64 + 4 * w), v, 3'b010, st);
            for (int i = 0; i < 4; i++) mref[4 * w + i] = v[8*i +: 8];
        end
        for (int it = 0; it < 300; it++) begin
            logic [31:0] ad = 32'(64 + $urandom_range(0, 63));
            logic [31:0] wd = $urandom;
            logic [2:0]  f3 = f3_pool[$urandom_range(0, 9)];
            logic        is_ld = 1'($urandom_range(0, 1));
            logic        flt = m_fault(ad, f3);
            logic [31:0] exp_rd = flt ? 32'd0 : m_load(ad, f3);
            do_req(is_ld, !is_ld, ad, wd, f3, st);
            check("rnd err", 32'(a_err), 32'(flt));
            check("rnd rd_valid", 32'(a_rd_valid), 32'(is_ld));
            if (is_ld) begin
                check("rnd rd_data", a_rd_data, exp_rd);
            end else if (!flt) begin
                for (int i = 0; i < acc_size(f3); i++) mref[ad - 64 + i] = wd[8*i +: 8];
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/data_mem_mmio.md
# data_mem_mmio

Parametrised data memory for the RV32 core's MEM stage. It replaces the fixed 256-word RAM and its hard-wired I/O words with a configurable number of memory-mapped input and output channels, each with a valid/ready handshake. It supports RV32 byte, half and word loads and stores with sign or zero extension. Loads are registered with a valid flag. A stall output holds the pipeline while an I/O channel is not ready.

## Interface
- DEPTH, 256: total word locations; I/O channels occupy the lowest indices, RAM the rest.
- NUM_IN, 1: input channels at word indices 0..NUM_IN-1 (1..8).
- NUM_OUT, 1: output channels at word indices NUM_IN..NUM_IN+NUM_OUT-1 (1..8).

- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- addr  in  32  byte address; word index = addr[31:2].
- wdata  in  32  store data, right-aligned.
- funct3  in  3  RV32 size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- lw_en  in  1  load request.
- sw_en  in  1  store request.
- rd_data  out  32  extended load result.
- rd_valid  out  1  rd_data valid, one-cycle pulse.
- err  out  1  faulted access, one-cycle pulse.
- stall  out  1  combinational: request not accepted this cycle; hold inputs.
- in_data  in  32*NUM_IN  channel k at bits [32k+31:32k].
- in_valid  in  NUM_IN  producer has data.
- in_ready  out  NUM_IN  combinational, equal to !in_full[k].
- out_data  out  32*NUM_OUT  channel register contents.
- out_valid  out  NUM_OUT  channel holds unconsumed data.
- out_ready  in  NUM_OUT  consumer accepts.

## Operation
- Little-endian byte lanes.
- Byte lane is addr[1:0]; half lane is addr[1].
- Misaligned access faults:
  - half access with addr[0]=1;
  - word access with addr[1:0]!=0.
- Also faulting: funct3 outside the listed codes, word index >= DEPTH, lw_en and sw_en both high, and a store to an input channel.
- A faulting access changes no state and never stalls.
- Input channel k:
  - Register in_reg[k] and flag in_full[k].
  - When in_valid[k] and in_ready[k] are both high, capture in_data and set in_full.
  - A load from channel k while in_full=0 stalls.
  - An accepted load returns in_reg (extracted and extended as for RAM) and clears in_full.
- Output channel k:
  - Register out_reg[k], driven on out_data.
  - out_valid clears when out_valid and out_ready are both high.
  - A store stalls when out_valid=1 and out_ready=0.
  - An accepted store merges its byte lanes into out_reg and sets out_valid.
  - A load reads out_reg back without side effects and never stalls.
- RAM region: a store writes only the selected byte lanes; a load extracts the addressed lanes and extends them per funct3.
- Stall rule: stall=1 means no state change for that request, rd_valid=0 next cycle, and the requester re-presents the request.

## Timing
- Store accepted in cycle N: committed at the posedge ending N; out_valid is high in N+1.
- Load accepted in cycle N: rd_data and rd_valid are valid in cycle N+1.
- rd_data holds its value until the next load completes.
- Faulting load in cycle N: rd_valid=1, rd_data=0 and err=1 in N+1.
- Faulting store in cycle N: err=1 in N+1.
- Back-to-back accepted loads give one result per cycle.
- Load of input channel k while in_full=1 in the same cycle as in_valid[k]=1:
  - the load returns the old value and in_full clears;
  - the new data is not taken that cycle (in_ready=0);
  - the new data is taken the next cycle.
- Store to output channel k while out_valid=1 and out_ready=1: accepted, out_reg updates, out_valid stays 1.
- Load of a RAM word in the cycle after a store to it returns the new data.
- Reset (synchronous, overrides everything, including mid-operation):
  - rd_data=0, rd_valid=0, err=0;
  - all in_full=0, all out_reg=0, all out_valid=0;
  - any pending load result is discarded;
  - RAM contents are not cleared.
- in_ready=1 in the first cycle after reset.

## Test plan
- RAM lanes: sw 0x80FF7F01 to byte address 0x40, then:
  - lb 0x40 -> 0x00000001;
  - lb 0x43 -> 0xFFFFFF80;
  - lbu 0x43 -> 0x00000080;
  - lh 0x42 -> 0xFFFF80FF;
  - lhu 0x42 -> 0x000080FF;
  - sb 0xAA to 0x41, then lw 0x40 -> 0x80FFAA01.
- Input handshake:
  - lw from addr 0 with in_valid=0 -> stall held, no rd_valid;
  - drive in_data=0x12345678 with in_valid -> in_ready=1, capture; next cycle the load completes with rd_data=0x12345678, rd_valid=1;
  - in_ready returns to 1.
- Output backpressure:
  - sw 0xDEADBEEF to output channel 0 (addr 4*NUM_IN) with out_ready=0 -> out_valid=1;
  - a second sw -> stall=1;
  - raise out_ready -> the second store is accepted and out_data updates.
- Faults, each -> err=1 with no state change:
  - lw at 0x41;
  - lh at 0x43;
  - sw to addr 0;
  - word index DEPTH;
  - funct3=011;
  - lw_en and sw_en both high.
- Reset mid-operation: issue a load, assert rst in the same cycle -> rd_valid=0, out_valid=0, in_ready=1 next cycle.
- Parameter sweep: NUM_IN=3, NUM_OUT=2, DEPTH=64:
  - the channel map is correct;
  - RAM starts at word 5;
  - word 63 is accessible;
  - word 64 faults.
